// File: rtl/mobo_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the motherboard port.
// Command/status encodings fall back to local values when no global constant
// header has defined them. MOBO_ARB_TIMEOUT_EN adds the arb_timeout signal.
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef CTRL_NONE
`define CTRL_NONE 0
`endif
`ifndef CTRL_READ
`define CTRL_READ 1
`endif
`ifndef CTRL_WRITE
`define CTRL_WRITE 2
`endif
`ifndef STAT_IDLE
`define STAT_IDLE 0
`endif
`ifndef STAT_DONE
`define STAT_DONE 1
`endif
`ifndef STAT_BUSY
`define STAT_BUSY 2
`endif

interface mobo_arbiter_if #(
   parameter int word_width = `WORD_WIDTH
);
   logic [word_width-1:0] req0_ctrl;
   logic [word_width-1:0] req0_stat;
   logic [word_width-1:0] req1_ctrl;
   logic [word_width-1:0] req1_stat;
   logic [word_width-1:0] mobo_ctrl;
   logic [word_width-1:0] mobo_stat;
   logic [1:0]            grant;
`ifdef MOBO_ARB_TIMEOUT_EN
   logic                  arb_timeout;
`endif

   // Arbiter side.
   modport slave (
      input  req0_ctrl, req1_ctrl, mobo_stat,
      output req0_stat, req1_stat, mobo_ctrl, grant
`ifdef MOBO_ARB_TIMEOUT_EN
      , output arb_timeout
`endif
   );

   // Requester / motherboard side.
   modport master (
      output req0_ctrl, req1_ctrl, mobo_stat,
      input  req0_stat, req1_stat, mobo_ctrl, grant
`ifdef MOBO_ARB_TIMEOUT_EN
      , input arb_timeout
`endif
   );
endinterface

// File: rtl/mobo_arbiter.sv
// Two-requester round-robin arbiter in front of a single motherboard port.
// FSM IDLE -> ISSUE -> RELEASE; the granted command is registered onto
// mobo_ctrl and the motherboard status is forwarded to the owner only.
// Optional watchdog on ISSUE: define MOBO_ARB_TIMEOUT_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef CTRL_NONE
`define CTRL_NONE 0
`endif
`ifndef CTRL_READ
`define CTRL_READ 1
`endif
`ifndef CTRL_WRITE
`define CTRL_WRITE 2
`endif
`ifndef STAT_IDLE
`define STAT_IDLE 0
`endif
`ifndef STAT_DONE
`define STAT_DONE 1
`endif
`ifndef STAT_BUSY
`define STAT_BUSY 2
`endif

module mobo_arbiter #(
   parameter int word_width     = `WORD_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic           clk,
   input logic           rst_n,
   mobo_arbiter_if.slave bus
);

   localparam logic [word_width-1:0] CTRL_NONE  = word_width'(`CTRL_NONE);
   localparam logic [word_width-1:0] CTRL_READ  = word_width'(`CTRL_READ);
   localparam logic [word_width-1:0] CTRL_WRITE = word_width'(`CTRL_WRITE);
   localparam logic [word_width-1:0] STAT_IDLE  = word_width'(`STAT_IDLE);
   localparam logic [word_width-1:0] STAT_DONE  = word_width'(`STAT_DONE);
   localparam logic [word_width-1:0] STAT_BUSY  = word_width'(`STAT_BUSY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RELEASE
   } state_e;

   // Only READ and WRITE are real commands; any other code counts as NONE.
   function automatic logic is_cmd(input logic [word_width-1:0] c);
      return (c == CTRL_READ) || (c == CTRL_WRITE);
   endfunction

   state_e                state_q, state_d;
   logic [word_width-1:0] cmd_q, cmd_d;      // registered mobo_ctrl
   logic [1:0]            grant_q, grant_d;  // one-hot owner
   logic                  prio_q, prio_d;    // 1: requester 1 wins a tie
   logic                  abort_q, abort_d;  // owner dropped its command in ISSUE
   logic [1:0]            req_v;
   logic [word_width-1:0] win_ctrl;
   logic [word_width-1:0] win_stat;
   logic                  timeout_hit;

`ifdef MOBO_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // Watchdog: counts ISSUE cycles from zero, fires on the last allowed one.
   always_comb begin
      cnt_d       = '0;
      timeout_hit = 1'b0;
      if (state_q == S_ISSUE) begin
         cnt_d       = cnt_q + CNT_W'(1);
         timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
      // A DONE arriving on the limit cycle is a normal completion, not a timeout.
      timeout_d = timeout_hit && (bus.mobo_stat != STAT_DONE);
   end

   // Watchdog registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.arb_timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;

   // The watchdog limit has no effect in this build.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   assign req_v    = {is_cmd(bus.req1_ctrl), is_cmd(bus.req0_ctrl)};
   assign win_ctrl = grant_q[1] ? bus.req1_ctrl : bus.req0_ctrl;

   // Next-state: arbitration in IDLE, completion/abort tracking in ISSUE,
   // handshake with the owner in RELEASE.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d = state_q;
      cmd_d   = cmd_q;
      grant_d = grant_q;
      prio_d  = prio_q;
      abort_d = abort_q;
      unique case (state_q)
         S_IDLE: begin
            if ((bus.mobo_stat == STAT_IDLE) && (req_v != 2'b00)) begin
               state_d = S_ISSUE;
               abort_d = 1'b0;
               if (req_v[1] && (!req_v[0] || prio_q)) begin
                  grant_d = 2'b10;
                  cmd_d   = bus.req1_ctrl;
               end else begin
                  grant_d = 2'b01;
                  cmd_d   = bus.req0_ctrl;
               end
            end
         end
         S_ISSUE: begin
            if (!is_cmd(win_ctrl)) abort_d = 1'b1;
            if ((bus.mobo_stat == STAT_DONE) || timeout_hit) begin
               state_d = S_RELEASE;
               cmd_d   = CTRL_NONE;
            end
         end
         S_RELEASE: begin
            if (!is_cmd(win_ctrl) && (bus.mobo_stat == STAT_IDLE)) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
               prio_d  = ~grant_q[1];  // the other requester wins the next tie
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values regardless of statement order.
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= CTRL_NONE;
         grant_q <= 2'b00;
         prio_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         grant_q <= grant_d;
         prio_q  <= prio_d;
         abort_q <= abort_d;
      end
   end

   // Status views: owner sees the motherboard (DONE withheld until RELEASE),
   // the other requester sees BUSY, everybody sees IDLE when no one owns it.
   always_comb begin
      win_stat      = STAT_IDLE;
      bus.req0_stat = STAT_IDLE;
      bus.req1_stat = STAT_IDLE;
      if (state_q == S_ISSUE) begin
         win_stat = (bus.mobo_stat == STAT_DONE) ? STAT_BUSY : bus.mobo_stat;
      end else if (state_q == S_RELEASE) begin
         win_stat = abort_q ? STAT_BUSY : STAT_DONE;
      end
      if (state_q != S_IDLE) begin
         if (grant_q[1]) begin
            bus.req1_stat = win_stat;
            bus.req0_stat = STAT_BUSY;
         end else begin
            bus.req0_stat = win_stat;
            bus.req1_stat = STAT_BUSY;
         end
      end
   end

   assign bus.mobo_ctrl = cmd_q;
   assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mobo_arbiter.sv
// Directed bench for mobo_arbiter; the bench plays both requesters and the
// motherboard. Define MOBO_ARB_TIMEOUT_EN to exercise the watchdog (limit 8).
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef CTRL_NONE
`define CTRL_NONE 0
`endif
`ifndef CTRL_READ
`define CTRL_READ 1
`endif
`ifndef CTRL_WRITE
`define CTRL_WRITE 2
`endif
`ifndef STAT_IDLE
`define STAT_IDLE 0
`endif
`ifndef STAT_DONE
`define STAT_DONE 1
`endif
`ifndef STAT_BUSY
`define STAT_BUSY 2
`endif

module tb_mobo_arbiter;
   localparam int W = 8;
   localparam logic [W-1:0] C_NONE  = W'(`CTRL_NONE);
   localparam logic [W-1:0] C_READ  = W'(`CTRL_READ);
   localparam logic [W-1:0] C_WRITE = W'(`CTRL_WRITE);
   localparam logic [W-1:0] S_IDLE  = W'(`STAT_IDLE);
   localparam logic [W-1:0] S_DONE  = W'(`STAT_DONE);
   localparam logic [W-1:0] S_BUSY  = W'(`STAT_BUSY);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   mobo_arbiter_if #(.word_width(W)) bus ();

   mobo_arbiter #(.word_width(W), .TIMEOUT_CYCLES(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0_ctrl = C_NONE;
      bus.req1_ctrl = C_NONE;
      bus.mobo_stat = S_IDLE;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.req0_ctrl = C_READ;  // reset must dominate a pending request
      cyc();
      cyc();
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL reset_mobo_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", bus.grant); end
      n_tests++; if (bus.req0_stat !== S_IDLE) begin n_fail++; $display("FAIL reset_req0_stat: got %0h expected %0h", bus.req0_stat, S_IDLE); end
      n_tests++; if (bus.req1_stat !== S_IDLE) begin n_fail++; $display("FAIL reset_req1_stat: got %0h expected %0h", bus.req1_stat, S_IDLE); end
      bus.req0_ctrl = C_NONE;
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single_read();
      bus.req0_ctrl = C_READ;
      #1;
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL single_idle_grant: got %b expected 00", bus.grant); end
      cyc();  // ISSUE, cycle 1
      n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", bus.grant); end
      n_tests++; if (bus.mobo_ctrl !== C_READ) begin n_fail++; $display("FAIL single_mobo_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_READ); end
      n_tests++; if (bus.req1_stat !== S_BUSY) begin n_fail++; $display("FAIL single_loser_stat: got %0h expected %0h", bus.req1_stat, S_BUSY); end
      bus.mobo_stat = S_BUSY;
      #1;
      n_tests++; if (bus.req0_stat !== S_BUSY) begin n_fail++; $display("FAIL single_fwd_busy: got %0h expected %0h", bus.req0_stat, S_BUSY); end
      cyc();
      cyc();  // ISSUE, cycle 3: device reports DONE
      bus.mobo_stat = S_DONE;
      #1;
      n_tests++; if (bus.req0_stat !== S_BUSY) begin n_fail++; $display("FAIL single_done_masked: got %0h expected %0h", bus.req0_stat, S_BUSY); end
      cyc();  // RELEASE
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL single_rel_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      n_tests++; if (bus.req0_stat !== S_DONE) begin n_fail++; $display("FAIL single_rel_stat: got %0h expected %0h", bus.req0_stat, S_DONE); end
      bus.mobo_stat = S_IDLE;
      cyc();  // requester still holds READ: stay in RELEASE
      n_tests++; if (bus.req0_stat !== S_DONE) begin n_fail++; $display("FAIL single_hold_done: got %0h expected %0h", bus.req0_stat, S_DONE); end
      n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL single_hold_grant: got %b expected 01", bus.grant); end
      bus.req0_ctrl = C_NONE;
      cyc();  // IDLE
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL single_end_grant: got %b expected 00", bus.grant); end
      n_tests++; if (bus.req0_stat !== S_IDLE) begin n_fail++; $display("FAIL single_end_stat: got %0h expected %0h", bus.req0_stat, S_IDLE); end
   endtask

   // Last winner was requester 0, so a tie now goes to requester 1; after a
   // reset the tie goes back to requester 0.
   task automatic test_round_robin();
      bus.req0_ctrl = C_WRITE;
      bus.req1_ctrl = C_WRITE;
      cyc();
      n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL rr1_first_grant: got %b expected 10", bus.grant); end
      n_tests++; if (bus.req0_stat !== S_BUSY) begin n_fail++; $display("FAIL rr1_loser_busy: got %0h expected %0h", bus.req0_stat, S_BUSY); end
      bus.mobo_stat = S_BUSY; cyc();
      bus.mobo_stat = S_DONE; cyc();
      n_tests++; if (bus.req1_stat !== S_DONE) begin n_fail++; $display("FAIL rr1_winner_done: got %0h expected %0h", bus.req1_stat, S_DONE); end
      n_tests++; if (bus.req0_stat !== S_BUSY) begin n_fail++; $display("FAIL rr1_loser_rel: got %0h expected %0h", bus.req0_stat, S_BUSY); end
      bus.req1_ctrl = C_NONE; bus.mobo_stat = S_IDLE; cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rr1_gap_grant: got %b expected 00", bus.grant); end
      cyc();
      n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL rr1_second_grant: got %b expected 01", bus.grant); end
      n_tests++; if (bus.mobo_ctrl !== C_WRITE) begin n_fail++; $display("FAIL rr1_second_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_WRITE); end
      bus.mobo_stat = S_DONE; cyc();
      bus.req0_ctrl = C_NONE; bus.mobo_stat = S_IDLE; cyc();

      do_reset();
      bus.req0_ctrl = C_WRITE;
      bus.req1_ctrl = C_WRITE;
      cyc();
      n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL rr2_first_grant: got %b expected 01", bus.grant); end
      n_tests++; if (bus.req1_stat !== S_BUSY) begin n_fail++; $display("FAIL rr2_loser_busy: got %0h expected %0h", bus.req1_stat, S_BUSY); end
      bus.mobo_stat = S_BUSY; cyc();
      bus.mobo_stat = S_DONE; cyc();
      bus.req0_ctrl = C_NONE; bus.mobo_stat = S_IDLE; cyc();
      cyc();
      n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL rr2_second_grant: got %b expected 10", bus.grant); end
      bus.mobo_stat = S_DONE; cyc();
      bus.req1_ctrl = C_NONE; bus.mobo_stat = S_IDLE; cyc();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         bus.req1_ctrl = C_READ;
         cyc();
         n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected 10", i, bus.grant); end
         n_tests++; if (bus.mobo_ctrl !== C_READ) begin n_fail++; $display("FAIL b2b_ctrl[%0d]: got %0h expected %0h", i, bus.mobo_ctrl, C_READ); end
         bus.mobo_stat = S_BUSY; cyc();
         bus.mobo_stat = S_DONE; cyc();
         n_tests++; if (bus.req1_stat !== S_DONE) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0h expected %0h", i, bus.req1_stat, S_DONE); end
         bus.req1_ctrl = C_NONE; bus.mobo_stat = S_IDLE; cyc();
      end
   endtask

   task automatic test_reset_mid_issue();
      bus.req0_ctrl = C_READ;
      cyc();
      bus.mobo_stat = S_BUSY; cyc();
      rst_n = 1'b0;
      bus.mobo_stat = S_DONE;
      #1;
      n_tests++; if (bus.req0_stat === S_DONE) begin n_fail++; $display("FAIL rst_mid_no_done_pre: got %0h expected not %0h", bus.req0_stat, S_DONE); end
      cyc();
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL rst_mid_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 00", bus.grant); end
      n_tests++; if (bus.req0_stat !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_req0_stat: got %0h expected %0h", bus.req0_stat, S_IDLE); end
      n_tests++; if (bus.req1_stat !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_req1_stat: got %0h expected %0h", bus.req1_stat, S_IDLE); end
      rst_n = 1'b1;
      idle_inputs();
      cyc();
   endtask

   task automatic test_abort();
      bus.req1_ctrl = C_WRITE;
      cyc();
      n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL abort_grant: got %b expected 10", bus.grant); end
      bus.mobo_stat = S_BUSY;
      bus.req1_ctrl = C_NONE;
      cyc();
      n_tests++; if (bus.mobo_ctrl !== C_WRITE) begin n_fail++; $display("FAIL abort_ctrl_held: got %0h expected %0h", bus.mobo_ctrl, C_WRITE); end
      bus.mobo_stat = S_DONE; cyc();  // RELEASE
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL abort_rel_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      n_tests++; if (bus.req1_stat === S_DONE) begin n_fail++; $display("FAIL abort_no_done: got %0h expected not %0h", bus.req1_stat, S_DONE); end
      cyc();  // device still shows DONE: remain in RELEASE
      n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL abort_wait_grant: got %b expected 10", bus.grant); end
      bus.mobo_stat = S_IDLE; cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL abort_end_grant: got %b expected 00", bus.grant); end
   endtask

   task automatic test_undefined_cmd();
      bus.req0_ctrl = 8'h7f;
      cyc();
      cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL undef_grant: got %b expected 00", bus.grant); end
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL undef_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      bus.req0_ctrl = 8'h03;
      bus.req1_ctrl = C_READ;
      cyc();
      n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL undef_mix_grant: got %b expected 10", bus.grant); end
      n_tests++; if (bus.mobo_ctrl !== C_READ) begin n_fail++; $display("FAIL undef_mix_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_READ); end
      bus.mobo_stat = S_DONE; cyc();
      idle_inputs(); cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL undef_end_grant: got %b expected 00", bus.grant); end
   endtask

   task automatic test_device_busy();
      bus.mobo_stat = S_BUSY;
      bus.req0_ctrl = C_READ;
      cyc();
      cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL busy_no_grant: got %b expected 00", bus.grant); end
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL busy_no_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      bus.mobo_stat = S_IDLE; cyc();
      n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL busy_then_grant: got %b expected 01", bus.grant); end
      bus.mobo_stat = S_DONE; cyc();
      idle_inputs(); cyc();
   endtask

`ifdef MOBO_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      bus.req0_ctrl = C_READ;
      cyc();  // ISSUE cycle 1
      bus.mobo_stat = S_BUSY;
      repeat (7) cyc();  // ISSUE cycle 8
      n_tests++; if (bus.mobo_ctrl !== C_READ) begin n_fail++; $display("FAIL to_pre_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_READ); end
      n_tests++; if (bus.arb_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pre_pulse: got %b expected 0", bus.arb_timeout); end
      cyc();
      n_tests++; if (bus.arb_timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b expected 1", bus.arb_timeout); end
      n_tests++; if (bus.mobo_ctrl !== C_NONE) begin n_fail++; $display("FAIL to_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_NONE); end
      n_tests++; if (bus.req0_stat !== S_DONE) begin n_fail++; $display("FAIL to_stat: got %0h expected %0h", bus.req0_stat, S_DONE); end
      cyc();
      n_tests++; if (bus.arb_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end: got %b expected 0", bus.arb_timeout); end
      idle_inputs(); cyc();
      n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL to_end_grant: got %b expected 00", bus.grant); end
   endtask
`else
   task automatic test_no_timeout();
      bus.req0_ctrl = C_READ;
      cyc();
      bus.mobo_stat = S_BUSY;
      repeat (40) cyc();
      n_tests++; if (bus.mobo_ctrl !== C_READ) begin n_fail++; $display("FAIL nto_ctrl: got %0h expected %0h", bus.mobo_ctrl, C_READ); end
      n_tests++; if (bus.req0_stat !== S_BUSY) begin n_fail++; $display("FAIL nto_stat: got %0h expected %0h", bus.req0_stat, S_BUSY); end
      bus.mobo_stat = S_DONE; cyc();
      n_tests++; if (bus.req0_stat !== S_DONE) begin n_fail++; $display("FAIL nto_done: got %0h expected %0h", bus.req0_stat, S_DONE); end
      idle_inputs(); cyc();
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_back_to_back();
      test_reset_mid_issue();
      test_abort();
      test_undefined_cmd();
      test_device_busy();
`ifdef MOBO_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mobo_arbiter.md
MOBO_ARBITER -- requirements
Module: mobo_arbiter

Interface
REQ-001 Parameter word_width, default `WORD_WIDTH, width of every ctrl/stat bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, ISSUE watchdog limit; used only with MOBO_ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0_ctrl  in  word_width  requester 0 command: `CTRL_NONE / `CTRL_READ / `CTRL_WRITE.
REQ-006 req0_stat  out  word_width  status view for requester 0.
REQ-007 req1_ctrl  in  word_width  requester 1 command, same encoding.
REQ-008 req1_stat  out  word_width  status view for requester 1.
REQ-009 mobo_ctrl  out  word_width  registered command to motherboard.
REQ-010 mobo_stat  in  word_width  motherboard status: `STAT_IDLE, `STAT_DONE, other = busy.
REQ-011 grant  out  2  one-hot owner, 2'b00 when idle.
REQ-012 arb_timeout  out  1  one-cycle timeout pulse; port present only with MOBO_ARB_TIMEOUT_EN.

Function
REQ-013 Requester contract: assert cmd on seeing `STAT_IDLE, hold it unchanged until own stat = `STAT_DONE, then drive `CTRL_NONE.
REQ-014 FSM states IDLE, ISSUE, RELEASE; ISSUE and RELEASE each last one or more cycles.
REQ-015 IDLE: mobo_ctrl = `CTRL_NONE, grant = 0, both reqN_stat = `STAT_IDLE.
REQ-016 IDLE -> ISSUE when mobo_stat = `STAT_IDLE and any reqN_ctrl != `CTRL_NONE; winner's cmd latched, grant set, same edge.
REQ-017 mobo_ctrl = latched cmd from the cycle after the IDLE request cycle (1-cycle latency); later changes on reqN_ctrl ignored until release.
REQ-018 Round-robin: one requester active -> it wins; both active -> non-last-winner wins; pointer after reset favours requester 0.
REQ-019 ISSUE: winner's stat = mobo_stat with `STAT_DONE masked to busy value; loser's stat = `STAT_BUSY (global_const.v).
REQ-020 ISSUE -> RELEASE on mobo_stat = `STAT_DONE; mobo_ctrl = `CTRL_NONE from next cycle.
REQ-021 RELEASE: winner's stat = `STAT_DONE, loser's = `STAT_BUSY; exit to IDLE when winner's ctrl = `CTRL_NONE and mobo_stat = `STAT_IDLE; pointer records winner on exit.
REQ-022 Pending loser keeps cmd held, so it is granted on the IDLE cycle after release; no request is lost.
REQ-023 Winner drops cmd to `CTRL_NONE during ISSUE (abort): motherboard transaction still completes; DONE consumed; RELEASE exits as soon as mobo_stat = `STAT_IDLE.
REQ-024 Undefined cmd codes (not NONE/READ/WRITE) are treated as `CTRL_NONE and never granted.

Reset
REQ-025 rst_n low at a clock edge: state IDLE, mobo_ctrl = `CTRL_NONE, grant = 0, pointer to requester 0, watchdog counter 0, arb_timeout = 0, both stat = `STAT_IDLE.
REQ-026 Reset mid-ISSUE/RELEASE abandons the transaction; no DONE is forwarded; mobo_ctrl = `CTRL_NONE from the edge after rst_n is sampled low.

Configuration
REQ-027 Macro MOBO_ARB_TIMEOUT_EN defined: counter clears on ISSUE entry, increments each ISSUE cycle, counter = TIMEOUT_CYCLES-1 without DONE -> RELEASE with mobo_ctrl = `CTRL_NONE, winner sees `STAT_DONE, arb_timeout pulses 1 cycle.
REQ-028 Macro undefined: no counter, no arb_timeout port; ISSUE waits for `STAT_DONE indefinitely.

Verification
REQ-029 Reset, req0 = `CTRL_READ, device DONE after 3 cycles -> grant = 01, mobo_ctrl = `CTRL_READ next cycle, req0_stat = `STAT_DONE until req0 drops, grant = 00.
REQ-030 req0 and req1 = `CTRL_WRITE in same cycle -> req0 served first, req1 sees `STAT_BUSY, then req1 served with no idle request dropped; repeat -> req1 first.
REQ-031 req1 only, 4 back-to-back reads -> each granted to req1, grant = 10 each time, no starvation stall.
REQ-032 rst_n low 1 cycle mid-ISSUE -> mobo_ctrl = `CTRL_NONE next cycle, grant = 00, no `STAT_DONE on either requester.
REQ-033 Winner drops cmd during ISSUE, device DONE later -> no DONE forwarded, IDLE after mobo_stat = `STAT_IDLE.
REQ-034 MOBO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, device never DONE -> arb_timeout pulse at 8th ISSUE cycle, mobo_ctrl = `CTRL_NONE, winner sees `STAT_DONE.
